// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code decoder: encode/decode functions,
// FSM state enum and error-counter width.
package johnson_pkg;

    localparam int unsigned JW_MAX   = 32;
    localparam int unsigned ERRCNT_W = 8;

    typedef enum logic {
        ACQ    = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Left-shift Johnson code of phase k for an n-bit ring; bits at and above n are zero.
    function automatic logic [JW_MAX-1:0] johnson_encode(input int unsigned n, input int unsigned k);
        logic [JW_MAX-1:0] enc;
        enc = '0;
        for (int unsigned i = 0; i < JW_MAX; i++) begin
            if (i < n) begin
                enc[i] = (k <= n) ? (i < k) : (i >= k - n);
            end
        end
        return enc;
    endfunction

    // Phase index from popcount; only meaningful when the word re-encodes to itself.
    function automatic int unsigned johnson_decode(input int unsigned n, input logic [JW_MAX-1:0] code);
        int unsigned p;
        p = 0;
        for (int unsigned i = 0; i < JW_MAX; i++) begin
            if (i < n) begin
                p += 32'(code[i]);
            end
        end
        if (code[n-1]) begin
            return 2 * n - p;
        end
        return p;
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational decode of one N-bit Johnson word into its phase index plus a
// legality flag (word must re-encode to itself exactly).
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  code,
    output logic [IW-1:0] k_c,
    output logic          legal_c
);

    logic [JW_MAX-1:0] code_ext;
    logic [JW_MAX-1:0] reenc;
    int unsigned       k_full;

    always_comb begin
        code_ext = JW_MAX'(code);
        k_full   = johnson_decode(N, code_ext);
        reenc    = johnson_encode(N, k_full);
        k_c      = IW'(k_full);
        legal_c  = (reenc == code_ext);
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: registered phase index, illegal/out-of-order flags and
// sequence-lock FSM. Optional saturating error counter under JOHNSON_DECODER_ERRCNT_EN.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter  int unsigned N        = 4,
    parameter  int unsigned LOCK_CNT = 3,
    localparam int unsigned IW       = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          code_valid,
    input  logic [N-1:0]  code_in,
    output logic [IW-1:0] idx,
    output logic          idx_valid,
    output logic          illegal,
    output logic          seq_err,
    output logic          locked
`ifdef JOHNSON_DECODER_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_cnt
`endif
);

    localparam int unsigned   RUN_W    = 4;
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

    logic [IW-1:0]    k_c;
    logic             legal_c;
    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic             have_prev_q, have_prev_d;
    logic [IW-1:0]    prev_q, prev_d;
    logic [IW-1:0]    idx_d;
    logic             idx_valid_d, illegal_d, seq_err_d;
    logic [IW-1:0]    expect_idx;
    logic             succ;

    johnson_code_check #(.N(N)) u_check (
        .code    (code_in),
        .k_c     (k_c),
        .legal_c (legal_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACQ;
            run_q       <= '0;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            idx         <= '0;
            idx_valid   <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            idx         <= idx_d;
            idx_valid   <= idx_valid_d;
            illegal     <= illegal_d;
            seq_err     <= seq_err_d;
            locked      <= (state_d == LOCKED);
        end
    end

    // Next-state and flag logic; a non-valid cycle leaves everything but the pulses untouched.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        idx_d       = idx;
        idx_valid_d = 1'b0;
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;
        expect_idx  = (prev_q == LAST_IDX) ? '0 : prev_q + IW'(1);
        succ        = have_prev_q && (k_c == expect_idx);
        run_inc     = run_q + RUN_W'(1);

        if (code_valid) begin
            idx_valid_d = 1'b1;
            if (!legal_c) begin
                illegal_d   = 1'b1;
                have_prev_d = 1'b0;
                run_d       = '0;
                state_d     = ACQ;
            end else begin
                idx_d       = k_c;
                prev_d      = k_c;
                have_prev_d = 1'b1;
                case (state_q)
                    ACQ: begin
                        if (succ) begin
                            run_d = run_inc;
                            if (run_inc == RUN_W'(LOCK_CNT)) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            run_d     = '0;
                            seq_err_d = have_prev_q;
                        end
                    end
                    LOCKED: begin
                        if (!succ) begin
                            seq_err_d = 1'b1;
                            run_d     = '0;
                            state_d   = ACQ;
                        end
                    end
                    default: state_d = ACQ;
                endcase
            end
        end
    end

`ifdef JOHNSON_DECODER_ERRCNT_EN
    // Saturating count of flagged samples; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if ((illegal_d || seq_err_d) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed/random bench for johnson_decoder (N=4, LOCK_CNT=3) with a queue scoreboard;
// define JOHNSON_DECODER_ERRCNT_EN to also check err_cnt.
module tb_johnson_decoder;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned L  = 2 * N;

    logic          clk;
    logic          rst_n;
    logic          code_valid;
    logic [N-1:0]  code_in;
    logic [IW-1:0] idx;
    logic          idx_valid;
    logic          illegal;
    logic          seq_err;
    logic          locked;
`ifdef JOHNSON_DECODER_ERRCNT_EN
    logic [7:0]    err_cnt;
`endif

    johnson_decoder #(.N(N), .LOCK_CNT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code_in    (code_in),
        .idx        (idx),
        .idx_valid  (idx_valid),
        .illegal    (illegal),
        .seq_err    (seq_err),
        .locked     (locked)
`ifdef JOHNSON_DECODER_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        int unsigned idx_valid;
        int unsigned illegal;
        int unsigned seq_err;
        int unsigned locked;
        int unsigned err_cnt;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // Reference sequence built by stepping the shift register itself.
    logic [N-1:0] seq_tbl [L];

    int unsigned m_idx, m_prev, m_run, m_err;
    bit          m_hp, m_locked;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_prev = 0; m_run = 0; m_err = 0; m_hp = 0; m_locked = 0;
    endtask

    task automatic model_step(input logic v, input logic [N-1:0] c, output exp_t e);
        int  pos;
        bit  succ;
        e.idx_valid = 0; e.illegal = 0; e.seq_err = 0;
        if (v) begin
            e.idx_valid = 1;
            pos = -1;
            for (int j = 0; j < int'(L); j++) if (seq_tbl[j] == c) pos = j;
            if (pos < 0) begin
                e.illegal = 1; m_hp = 0; m_run = 0; m_locked = 0;
            end else begin
                succ = m_hp && (int'(pos) == int'((m_prev + 1) % L));
                if (m_locked) begin
                    if (!succ) begin e.seq_err = 1; m_locked = 0; m_run = 0; end
                end else if (succ) begin
                    m_run++;
                    if (m_run == 3) m_locked = 1;
                end else begin
                    m_run = 0; e.seq_err = m_hp;
                end
                m_idx = pos; m_prev = pos; m_hp = 1;
            end
            if ((e.illegal || e.seq_err) && m_err < 255) m_err++;
        end
        e.idx = m_idx; e.locked = m_locked; e.err_cnt = m_err;
    endtask

    task automatic check_out(input exp_t e);
        chk("idx", idx, e.idx);
        chk("idx_valid", idx_valid, e.idx_valid);
        chk("illegal", illegal, e.illegal);
        chk("seq_err", seq_err, e.seq_err);
        chk("locked", locked, e.locked);
        chk("flag_excl", 32'(illegal & seq_err), 0);
`ifdef JOHNSON_DECODER_ERRCNT_EN
        chk("err_cnt", err_cnt, e.err_cnt);
`endif
    endtask

    // Drive one sample, queue its expectation, compare when the registered result appears.
    task automatic cycle(input logic v, input logic [N-1:0] c);
        exp_t e;
        code_valid = v;
        code_in    = c;
        model_step(v, c, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            check_out(exp_q.pop_front());
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_idx"}, idx, 0);
        chk({tag, "_idx_valid"}, idx_valid, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_seq_err"}, seq_err, 0);
        chk({tag, "_locked"}, locked, 0);
`ifdef JOHNSON_DECODER_ERRCNT_EN
        chk({tag, "_err_cnt"}, err_cnt, 0);
`endif
    endtask

    initial begin
        logic [N-1:0] q;
        logic [N-1:0] c;
        logic         v;
        int unsigned  r;

        q = '0;
        for (int j = 0; j < int'(L); j++) begin
            seq_tbl[j] = q;
            q = {q[N-2:0], ~q[N-1]};
        end
        model_reset();

        rst_n = 1'b0; code_valid = 1'b0; code_in = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean run from 0011: lock reported together with idx 5.
        cycle(1, 4'b0011); cycle(1, 4'b0111); cycle(1, 4'b1111); cycle(1, 4'b1110);
        chk("lock_idx5", idx, 5);
        chk("lock_at_idx5", locked, 1);
        // Wrap through 0000 while locked.
        cycle(1, 4'b1100); cycle(1, 4'b1000); cycle(1, 4'b0000); cycle(1, 4'b0001);
        chk("wrap_idx", idx, 1);
        chk("wrap_locked", locked, 1);

        // Illegal word holds idx, drops lock; next legal word only seeds.
        cycle(1, 4'b0101);
        chk("illegal_hold_idx", idx, 1);
        chk("illegal_flag", illegal, 1);
        cycle(1, 4'b0111);
        chk("seed_no_seqerr", seq_err, 0);
        cycle(1, 4'b1111); cycle(1, 4'b1110); cycle(1, 4'b1100);
        chk("relock_after_illegal", locked, 1);

        // Skip step while locked, then relock on the third correct step.
        cycle(1, 4'b1000); cycle(1, 4'b0000); cycle(1, 4'b0001);
        cycle(1, 4'b0111);
        chk("skip_seq_err", seq_err, 1);
        chk("skip_unlock", locked, 0);
        cycle(1, 4'b1111); cycle(1, 4'b1110);
        chk("not_yet_locked", locked, 0);
        cycle(1, 4'b1100);
        chk("relock_third", locked, 1);

        // Gap with garbage on the bus, then a repeated word.
        for (int g = 0; g < 5; g++) cycle(0, 4'(g * 3 + 5));
        cycle(1, 4'b1000);
        cycle(1, 4'b1000);
        chk("repeat_seq_err", seq_err, 1);

        // Random mix of successors, arbitrary legal words and arbitrary patterns.
        for (int t = 0; t < 120; t++) begin
            r = $urandom_range(0, 99);
            v = ($urandom_range(0, 3) != 0);
            if (r < 70)      c = seq_tbl[(m_prev + 1) % L];
            else if (r < 85) c = seq_tbl[$urandom_range(0, L - 1)];
            else             c = 4'($urandom_range(0, 15));
            cycle(v, c);
        end

`ifdef JOHNSON_DECODER_ERRCNT_EN
        for (int t = 0; t < 300; t++) cycle(1, 4'b1010);
        chk("err_cnt_sat", err_cnt, 255);
`endif

        // Asynchronous reset mid-stream, then the first sample only seeds.
        cycle(1, 4'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        code_valid = 1'b1; code_in = 4'b0111;
        @(posedge clk); #1;
        check_all_zero("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 4'b0011);
        chk("post_rst_seed_idx", idx, 2);
        chk("post_rst_seed_seq", seq_err, 0);
        cycle(1, 4'b0111);
        cycle(0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
